// File: rtl/uart_rx_fifo_port.sv
// Memory-mapped UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a receive FIFO.
// Registers: 0 RXDATA (read pops), 1 STATUS (write-1-to-clear sticky bits 2..4).
module uart_rx_fifo_port #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic        Select,
  input  logic        Write,
  input  logic        Read,
  output logic [31:0] DataOut,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] FullReload = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfReload = CntW'(ClksPerBit / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            push_q, push_d;
  logic            frame_set, par_set;
  logic            rx_meta_q, rxs_q, rxs_prev_q;

  logic [AddrW:0]  wptr_q, rptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            empty, full, pop_cond, pop_seen_q, pop, do_push;
  logic            wr_status;
  logic            overrun_q, frame_err_q, parity_err_q;
  logic [2:0]      clr;

  logic unused_bits;
  assign unused_bits = ^{Address[31:4], Address[1:0], DataIn[31:5], DataIn[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = HalfReload;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs_q) begin
          state_d = StIdle;
        end else begin
          cnt_d     = FullReload;
          idx_d     = '0;
          par_bad_d = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FullReload;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          if (rxs_q != ^shift_q) begin
            par_set   = 1'b1;
            par_bad_d = 1'b1;
          end
          cnt_d   = FullReload;
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!rxs_q) frame_set = 1'b1;
          else if (!par_bad_q) push_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      push_q    <= push_d;
    end
  end

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop_cond  = Select && Read && (Address[3:2] == 2'd0);
  // Only the first cycle of a held read pops.
  assign pop       = pop_cond && !pop_seen_q && !empty;
  assign do_push   = push_q && (!full || pop);
  assign wr_status = Select && Write && (Address[3:2] == 2'd1);
  assign clr       = wr_status ? DataIn[4:2] : 3'b000;
  assign rx_irq    = !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      pop_seen_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      pop_seen_q   <= pop_cond;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      overrun_q    <= (overrun_q & ~clr[0]) | (push_q & full & ~pop);
      frame_err_q  <= (frame_err_q & ~clr[1]) | frame_set;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= (parity_err_q & ~clr[2]) | par_set;
`else
      parity_err_q <= 1'b0;
`endif
    end
  end

  always_comb begin
    DataOut = '0;
    if (Select) begin
      unique case (Address[3:2])
        2'd0:    DataOut = empty ? 32'd0 : {24'd0, mem_q[rptr_q[AddrW-1:0]]};
        2'd1:    DataOut = {27'd0, parity_err_q, frame_err_q, overrun_q, full, !empty};
        default: DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_port.sv
// Directed bench for uart_rx_fifo_port with a queue-based model of FIFO contents and sticky bits.
module tb_uart_rx_fifo_port;

  localparam int Cpb   = 16;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic        Select = 1'b0;
  logic        Write = 1'b0;
  logic        Read = 1'b0;
  logic [31:0] DataOut;
  logic        rx = 1'b1;
  logic        rx_irq;

  uart_rx_fifo_port #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Address(Address),
    .DataIn (DataIn),
    .Select (Select),
    .Write  (Write),
    .Read   (Read),
    .DataOut(DataOut),
    .rx     (rx),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  logic [7:0] model_q[$];
  bit m_ovr, m_frm, m_par;
  bit settled = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {27'd0, m_par, m_frm, m_ovr, model_q.size() == Depth, model_q.size() != 0};
  endfunction

  always @(negedge clk) begin
    if (rst && settled) begin
      check("rx_irq", {31'd0, rx_irq}, {31'd0, model_q.size() != 0});
      if (!Select) check("dataout_deselected", DataOut, 32'd0);
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_val, input bit par_flip);
    bit par_bad;
    settled = 1'b0;
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
    par_bad = par_flip;
`endif
    drive_bit(stop_val);
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    if (par_bad) m_par = 1'b1;
    if (!stop_val) m_frm = 1'b1;
    else if (!par_bad) begin
      if (model_q.size() == Depth) m_ovr = 1'b1;
      else model_q.push_back(d);
    end
    settled = 1'b1;
  endtask

  // Hold a read for `cycles` cycles; value sampled in the first cycle and checked against the model.
  task automatic bus_read(input logic [1:0] a, input int cycles, output logic [31:0] v);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    Address = {28'd0, a, 2'b00};
    Select  = 1'b1;
    Read    = 1'b1;
    if (a == 2'd0) exp = (model_q.size() != 0) ? {24'd0, model_q[0]} : 32'd0;
    else if (a == 2'd1) exp = model_status();
    else exp = 32'd0;
    @(negedge clk);
    v = DataOut;
    check($sformatf("read_addr%0d", a), v, exp);
    @(posedge clk);
    #1;
    if (a == 2'd0 && model_q.size() != 0) void'(model_q.pop_front());
    repeat (cycles - 1) @(posedge clk);
    #1;
    Select = 1'b0;
    Read   = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    Address = {28'd0, a, 2'b00};
    DataIn  = d;
    Select  = 1'b1;
    Write   = 1'b1;
    @(posedge clk);
    #1;
    Select = 1'b0;
    Write  = 1'b0;
    if (a == 2'd1) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_frm = 1'b0;
      if (d[4]) m_par = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    m_par = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    settled = 1'b1;
    repeat (2) @(posedge clk);

    // Reset values, then a reset asserted mid-frame.
    check("irq_after_reset", {31'd0, rx_irq}, 32'd0);
    bus_read(2'd1, 1, v);
    check("status_reset", v, 32'h0);
    settled = 1'b0;
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    settled = 1'b1;
    bus_read(2'd1, 1, v);
    check("status_after_midframe_reset", v, 32'h0);
    bus_read(2'd0, 1, v);
    check("rxdata_after_midframe_reset", v, 32'h0);
    check("irq_after_midframe_reset", {31'd0, rx_irq}, 32'd0);

    // Single byte.
    send_frame(8'h55, 1'b1, 1'b0);
    bus_read(2'd1, 1, v);
    check("status_one_byte", v, 32'h1);
    check("irq_one_byte", {31'd0, rx_irq}, 32'd1);
    bus_read(2'd0, 1, v);
    check("rxdata_55", v, 32'h55);
    bus_read(2'd1, 1, v);
    check("status_drained", v, 32'h0);

    // Overrun: nine bytes into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    bus_read(2'd1, 1, v);
    check("status_overrun", v, 32'h7);
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0, 1, v);
      check("rxdata_ordered", v, 32'(i));
    end
    bus_read(2'd0, 1, v);
    check("rxdata_empty", v, 32'h0);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, 1, v);
    check("status_overrun_cleared", v, 32'h0);

    // Frame error, then a good byte.
    send_frame(8'hA3, 1'b0, 1'b0);
    bus_read(2'd1, 1, v);
    check("status_frame_err", v, 32'h8);
    send_frame(8'h3C, 1'b1, 1'b0);
    bus_read(2'd1, 1, v);
    check("status_frame_err_plus_data", v, 32'h9);
    bus_read(2'd0, 1, v);
    check("rxdata_3c", v, 32'h3C);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, 1, v);
    check("status_frame_err_cleared", v, 32'h0);

    // Glitch shorter than half a bit, then a held read that must pop once.
    settled = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * Cpb) @(posedge clk);
    #1;
    settled = 1'b1;
    bus_read(2'd1, 1, v);
    check("status_after_glitch", v, 32'h0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    bus_read(2'd0, 3, v);
    check("rxdata_11_held", v, 32'h11);
    bus_read(2'd0, 1, v);
    check("rxdata_22", v, 32'h22);
    bus_read(2'd1, 1, v);
    check("status_after_held_read", v, 32'h0);

    // Unused registers read zero.
    bus_read(2'd2, 1, v);
    check("reg2_zero", v, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    bus_read(2'd1, 1, v);
    check("status_parity_err", v, 32'h10);
    send_frame(8'h07, 1'b1, 1'b0);
    bus_read(2'd0, 1, v);
    check("rxdata_07_parity_ok", v, 32'h07);
    bus_write(2'd1, 32'h10);
    bus_read(2'd1, 1, v);
    check("status_parity_cleared", v, 32'h0);
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_port.md
# uart_rx_fifo_port

Memory-mapped UART receiver with a receive FIFO, attached to the processor's memory-map decoder as a peripheral slave. Deserialises 8N1 frames from the `rx` pin using mid-bit sampling and buffers received bytes in a FIFO. Exposes data, sticky error status and a not-empty interrupt line to the multicycle core through word-addressed registers.

## Interface
- `CLK_FREQ`, 50_000_000: core clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE`, truncated; 434 at defaults.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `Address` input 32: byte address from the decoder; only `Address[3:2]` are decoded.
- `DataIn` input 32: write data from the core.
- `Select` input 1: chip select from the decoder.
- `Write` input 1: write strobe, qualified by `Select`.
- `Read` input 1: read strobe, qualified by `Select`.
- `DataOut` output 32: read data; combinational.
- `rx` input 1: serial line, asynchronous to `clk`.
- `rx_irq` output 1: high while the FIFO is not empty.

## Operation
- **Register map** (decoded from `Address[3:2]`):
  - 0: RXDATA, read-only. Returns `{24'b0, head}` when the FIFO is non-empty, else 0.
  - 1: STATUS. Bit 0 not_empty, bit 1 full, bit 2 overrun, bit 3 frame_err, bit 4 parity_err; all other bits 0.
  - 2–3: read 0, writes ignored.
  - `DataOut` = 0 whenever `Select`=0.
- **Sticky clear:** a write to STATUS with `DataIn` bit n = 1 clears sticky bit n (n = 2..4). Bits 0–1 are read-only.
- **Pop:**
  - Pop condition: `Select & Read & Address[3:2]==0`.
  - One pop on the first cycle that condition holds; a registered copy suppresses further pops until it deasserts. A multicycle read holding the condition therefore pops exactly once.
  - Pop when empty: ignored.
- **Input synchroniser:** 2-FF chain, both flops reset to 1. The FSM uses the synchronised value `rxs` only.
- **Receive FSM:**
  - IDLE: a 1→0 transition on `rxs` loads the baud counter and moves to START. A line held low never restarts without first returning high.
  - START: at `CLKS_PER_BIT/2` cycles, if `rxs`=1 the event is a glitch: return to IDLE, nothing recorded. Otherwise reload the counter and move to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first, 8 bits via a 3-bit index. Then move to STOP, or to PARITY when that feature is compiled in.
  - STOP: sample once.
    - `rxs`=1: push the byte.
    - `rxs`=0: set frame_err and discard the byte.
    - Either way, go to IDLE.
- **Push:**
  - FIFO full and no pop in the same cycle: byte dropped, overrun set.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This also applies when full; no overrun in that case.
- **FIFO pointers:** read/write pointers are `log2(FIFO_DEPTH)+1` bits and wrap modulo 2·depth.
  - Empty: pointers are equal.
  - Full: MSBs differ and the remaining bits are equal.
- **Reset mid-frame:** FSM returns to IDLE, FIFO empties, sticky bits clear, partial byte is lost.

## Timing
- **Reset values:** `DataOut`=0, `rx_irq`=0, FSM IDLE, pointers 0, all sticky bits 0, synchroniser 1.
- **Start detection:** `rx` falling edge to START entry is 3 cycles (2 synchroniser + 1 edge detect).
- **Push timing:** a byte is pushed on the cycle after the mid-stop-bit sample. `rx_irq` and not_empty rise one cycle later.
- **Pop timing:** the FIFO head advances on the clock edge ending the pop cycle. `DataOut` shows the new head in the next cycle.
- **Sticky bits:** set and clear take effect on the next edge. A set coinciding with a clear of the same bit wins (set dominates).
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`; it counts down to 0 and reloads.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - The FSM adds a PARITY state between DATA and STOP, sampling one even-parity bit.
  - On mismatch, parity_err is set and the byte is discarded even if the stop bit is valid.
  - Frame format is 8E1.
- **Undefined:**
  - No PARITY state; frame format is 8N1.
  - STATUS bit 4 reads 0; writes to it have no effect.

## Test plan
1. **Reset:** assert `rst`=0 mid-frame, release. Expect STATUS reads 0x0, RXDATA reads 0x0, `rx_irq`=0.
2. **Single byte:** defaults, 0x55 sent at 115200 baud. Expect STATUS=0x1, `rx_irq`=1; RXDATA read returns 0x55; then STATUS=0x0 and `rx_irq`=0.
3. **Overrun:** send 0x01..0x09 with no reads, `FIFO_DEPTH`=8.
   - Expect STATUS=0x7 (not_empty, full, overrun).
   - Eight reads return 0x01..0x08 in order; a ninth read returns 0.
   - Writing STATUS 0x4 clears overrun, giving STATUS=0x0.
4. **Frame error:** send 0xA3 with the stop bit driven 0. Expect STATUS=0x8 and FIFO empty. After `rx` returns high, a following 0x3C is received correctly (STATUS=0x9).
5. **Glitch and single pop:**
   - A 100-cycle low pulse on `rx` leaves STATUS=0x0 and the FSM back in IDLE.
   - Then send 0x11, 0x22 and hold a RXDATA read (`Select`, `Read`) for 3 cycles: exactly one pop, and the next read returns 0x22.
6. **Parity (`UART_RX_PARITY_EN` only):** send 0x07 with odd parity bit. Expect STATUS=0x10 and FIFO empty. Then 0x07 with correct even parity returns 0x07.
